// File: rtl/pll_seq_pkg.sv
// Shared types and constants for the PLL lock sequencer.
package pll_seq_pkg;

    typedef enum logic [1:0] {
        PLL_RST   = 2'd0,
        WAIT_LOCK = 2'd1,
        STABLE    = 2'd2,
        RUN       = 2'd3
    } pll_seq_state_t;

    localparam int unsigned RETRY_MAX = 255;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for asynchronous level inputs; resets to 0.
module sync_2ff #(
    parameter int unsigned WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/pll_lock_sequencer.sv
// PLL reset/lock sequencer: pulses the PLL reset, waits for stable lock, then releases core reset.
// Build option PLL_SEQ_LOSS_DEBOUNCE_EN: lock loss in RUN needs LOSS_FILTER consecutive unlocked cycles.
module pll_lock_sequencer
    import pll_seq_pkg::*;
#(
    parameter int unsigned PLL_RST_CYCLES = 16,
    parameter int unsigned LOCK_TIMEOUT   = 1000000,
    parameter int unsigned STABLE_CYCLES  = 65536,
    parameter int unsigned LOSS_FILTER    = 4
) (
    input  logic       clk_74a,
    input  logic       reset_n,
    input  logic       pll_locked,
    input  logic       soft_restart,
    output logic       pll_rst,
    output logic       core_reset_n,
    output logic       running,
    output logic       lock_lost,
    output logic [7:0] retry_count
);

    localparam int unsigned MAX_A   = (PLL_RST_CYCLES > LOCK_TIMEOUT) ? PLL_RST_CYCLES : LOCK_TIMEOUT;
    localparam int unsigned MAX_B   = (STABLE_CYCLES > LOSS_FILTER) ? STABLE_CYCLES : LOSS_FILTER;
    localparam int unsigned CNT_MAX = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int unsigned CNT_W   = (CNT_MAX > 2) ? $clog2(CNT_MAX) : 1;

    localparam logic [CNT_W-1:0] RST_LAST     = CNT_W'(PLL_RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(STABLE_CYCLES - 1);

    pll_seq_state_t   state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [7:0]       retry_d;
    logic             lost_d;
    logic             locked_s;
    logic             loss_c;

    sync_2ff #(.WIDTH(1)) u_lock_sync (
        .clk   (clk_74a),
        .rst_n (reset_n),
        .d     (pll_locked),
        .q     (locked_s)
    );

`ifdef PLL_SEQ_LOSS_DEBOUNCE_EN
    localparam int unsigned      FILT_W    = (LOSS_FILTER > 1) ? $clog2(LOSS_FILTER + 1) : 1;
    localparam logic [FILT_W-1:0] FILT_LAST = FILT_W'(LOSS_FILTER - 1);

    logic [FILT_W-1:0] filt_q, filt_d;

    // Counts consecutive unlocked cycles in RUN; any locked cycle clears it.
    always_comb begin
        filt_d = '0;
        loss_c = 1'b0;
        if (state_q == RUN && !locked_s) begin
            if (filt_q == FILT_LAST) begin
                loss_c = 1'b1;
            end else begin
                filt_d = filt_q + FILT_W'(1);
            end
        end
    end

    always_ff @(posedge clk_74a or negedge reset_n) begin
        if (!reset_n) begin
            filt_q <= '0;
        end else begin
            filt_q <= filt_d;
        end
    end
`else
    assign loss_c = (state_q == RUN) && !locked_s;
`endif

    // Next-state, shared counter and sticky status.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + CNT_W'(1);
        retry_d = retry_count;
        lost_d  = lock_lost;
        if (soft_restart) begin
            state_d = PLL_RST;
            cnt_d   = '0;
            lost_d  = 1'b0;
        end else begin
            case (state_q)
                PLL_RST: begin
                    if (cnt_q == RST_LAST) begin
                        state_d = WAIT_LOCK;
                        cnt_d   = '0;
                    end
                end
                WAIT_LOCK: begin
                    // Lock beats a coincident timeout.
                    if (locked_s) begin
                        state_d = STABLE;
                        cnt_d   = '0;
                    end else if (cnt_q == TIMEOUT_LAST) begin
                        state_d = PLL_RST;
                        cnt_d   = '0;
                        if (retry_count != 8'(RETRY_MAX)) begin
                            retry_d = retry_count + 8'd1;
                        end
                    end
                end
                STABLE: begin
                    if (!locked_s) begin
                        state_d = WAIT_LOCK;
                        cnt_d   = '0;
                    end else if (cnt_q == STABLE_LAST) begin
                        state_d = RUN;
                        cnt_d   = '0;
                    end
                end
                RUN: begin
                    cnt_d = '0;
                    if (loss_c) begin
                        state_d = WAIT_LOCK;
                        lost_d  = 1'b1;
                    end
                end
                default: begin
                    state_d = PLL_RST;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // Outputs are decoded from the next state so they switch on the same edge as the state.
    always_ff @(posedge clk_74a or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= PLL_RST;
            cnt_q        <= '0;
            pll_rst      <= 1'b1;
            core_reset_n <= 1'b0;
            running      <= 1'b0;
            lock_lost    <= 1'b0;
            retry_count  <= 8'd0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            pll_rst      <= (state_d == PLL_RST);
            core_reset_n <= (state_d == RUN);
            running      <= (state_d == RUN);
            lock_lost    <= lost_d;
            retry_count  <= retry_d;
        end
    end

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Scoreboard bench for pll_lock_sequencer: stimulus queues per-cycle expectations, a negedge monitor checks them.
module tb_pll_lock_sequencer;

    logic       clk_74a = 1'b0;
    logic       reset_n;
    logic       pll_locked;
    logic       soft_restart;
    logic       pll_rst;
    logic       core_reset_n;
    logic       running;
    logic       lock_lost;
    logic [7:0] retry_count;

    int unsigned cyc   = 0;
    int unsigned total = 0;
    int unsigned bad   = 0;

    typedef struct {
        int unsigned cyc;
        logic        pll_rst;
        logic        core_reset_n;
        logic        running;
        logic        lock_lost;
        logic [7:0]  retry;
        string       name;
    } exp_t;

    exp_t sb[$];
    exp_t e;

    pll_lock_sequencer #(
        .PLL_RST_CYCLES (4),
        .LOCK_TIMEOUT   (20),
        .STABLE_CYCLES  (8),
        .LOSS_FILTER    (3)
    ) dut (
        .clk_74a      (clk_74a),
        .reset_n      (reset_n),
        .pll_locked   (pll_locked),
        .soft_restart (soft_restart),
        .pll_rst      (pll_rst),
        .core_reset_n (core_reset_n),
        .running      (running),
        .lock_lost    (lock_lost),
        .retry_count  (retry_count)
    );

    always #5 clk_74a = ~clk_74a;

    always @(posedge clk_74a) cyc <= cyc + 1;

    // Queue an expectation for the outputs seen after rising edge number cyc+d.
    task automatic push(input int unsigned d, input logic p, input logic c, input logic r,
                        input logic l, input int unsigned rc, input string nm);
        exp_t x;
        int   i;
        x.cyc = cyc + d;
        x.pll_rst = p;
        x.core_reset_n = c;
        x.running = r;
        x.lock_lost = l;
        x.retry = 8'(rc);
        x.name = nm;
        i = sb.size();
        while (i > 0 && sb[i-1].cyc > x.cyc) i--;
        sb.insert(i, x);
    endtask

    task automatic tick(input int unsigned n);
        repeat (n) @(posedge clk_74a);
        #1;
    endtask

    // Monitor: compare every expectation due at this cycle.
    always @(negedge clk_74a) begin
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            e = sb.pop_front();
            total++;
            if (e.cyc < cyc) begin
                bad++;
                $display("FAIL %s: missed cycle %0d (now %0d)", e.name, e.cyc, cyc);
            end else if ({pll_rst, core_reset_n, running, lock_lost, retry_count} !==
                         {e.pll_rst, e.core_reset_n, e.running, e.lock_lost, e.retry}) begin
                bad++;
                $display("FAIL %s @%0d: got pll_rst=%b core_reset_n=%b running=%b lock_lost=%b retry=%0d, want %b %b %b %b %0d",
                         e.name, cyc, pll_rst, core_reset_n, running, lock_lost, retry_count,
                         e.pll_rst, e.core_reset_n, e.running, e.lock_lost, e.retry);
            end
        end
    end

    initial begin
        #200us;
        $display("FAIL watchdog: simulation time limit reached, cycle=%0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n      = 1'b0;
        pll_locked   = 1'b0;
        soft_restart = 1'b0;

        // Reset values, then release with lock arriving 10 cycles later.
        push(2, 1, 0, 0, 0, 0, "reset_vals");
        tick(3);
        reset_n = 1'b1;
        push(3, 1, 0, 0, 0, 0, "pll_rst_last_hi");
        push(4, 0, 0, 0, 0, 0, "pll_rst_low");
        tick(10);
        pll_locked = 1'b1;
        push(10, 0, 0, 0, 0, 0, "pre_release");
        push(11, 0, 1, 1, 0, 0, "core_release");
        tick(13);

        // One-cycle lock dropout in RUN.
        pll_locked = 1'b0;
`ifdef PLL_SEQ_LOSS_DEBOUNCE_EN
        push(3, 0, 1, 1, 0, 0, "glitch_ignored");
        push(12, 0, 1, 1, 0, 0, "glitch_still_run");
        tick(1);
        pll_locked = 1'b1;
        tick(12);
        // Three-cycle dropout trips the filter.
        pll_locked = 1'b0;
        push(4, 0, 1, 1, 0, 0, "deb_before_loss");
        push(5, 0, 0, 0, 1, 0, "deb_loss");
        push(14, 0, 1, 1, 1, 0, "deb_rerun_sticky");
        tick(3);
        pll_locked = 1'b1;
        tick(13);
`else
        push(2, 0, 1, 1, 0, 0, "run_before_loss");
        push(3, 0, 0, 0, 1, 0, "loss_core_low");
        push(12, 0, 1, 1, 1, 0, "rerun_sticky");
        tick(1);
        pll_locked = 1'b1;
        tick(13);
`endif

        // Soft restart in RUN with lock_lost set, then 60 unlocked cycles of retries.
        soft_restart = 1'b1;
        pll_locked   = 1'b0;
        push(1, 1, 0, 0, 0, 0, "soft_pll_rst");
        push(4, 1, 0, 0, 0, 0, "soft_rst_end");
        push(5, 0, 0, 0, 0, 0, "first_wait");
        push(24, 0, 0, 0, 0, 0, "pre_timeout1");
        push(25, 1, 0, 0, 0, 1, "timeout1");
        push(28, 1, 0, 0, 0, 1, "timeout1_hi");
        push(29, 0, 0, 0, 0, 1, "timeout1_lo");
        push(48, 0, 0, 0, 0, 1, "pre_timeout2");
        push(49, 1, 0, 0, 0, 2, "timeout2");
        tick(1);
        soft_restart = 1'b0;
        tick(59);

        // Lock, then a 2-cycle dropout inside STABLE.
        pll_locked = 1'b1;
        push(3, 0, 0, 0, 0, 2, "stable_entry");
        push(9, 0, 0, 0, 0, 2, "dropout_no_retry");
        push(11, 0, 0, 0, 0, 2, "stable_restarted");
        push(17, 0, 0, 0, 0, 2, "pre_rerun");
        push(18, 0, 1, 1, 0, 2, "rerun_after_drop");
        tick(5);
        pll_locked = 1'b0;
        tick(2);
        pll_locked = 1'b1;
        tick(13);

        // Saturation over 300 forced timeouts; soft restart keeps the count.
        soft_restart = 1'b1;
        pll_locked   = 1'b0;
        push(1, 1, 0, 0, 0, 2, "soft_keeps_retry");
        push(24 + 24 * 252, 0, 0, 0, 0, 254, "pre_saturate");
        push(25 + 24 * 252, 1, 0, 0, 0, 255, "saturate");
        push(25 + 24 * 299, 1, 0, 0, 0, 255, "saturate_hold");
        tick(1);
        soft_restart = 1'b0;
        tick(24 + 24 * 299);

        // Asynchronous reset while in STABLE.
        soft_restart = 1'b1;
        pll_locked   = 1'b1;
        push(6, 0, 0, 0, 0, 255, "stable_before_reset");
        tick(1);
        soft_restart = 1'b0;
        tick(7);
        reset_n = 1'b0;
        #2;
        total++;
        if ({pll_rst, core_reset_n, running, lock_lost, retry_count} !== {1'b1, 1'b0, 1'b0, 1'b0, 8'd0}) begin
            bad++;
            $display("FAIL async_reset: got pll_rst=%b core_reset_n=%b running=%b lock_lost=%b retry=%0d, want 1 0 0 0 0",
                     pll_rst, core_reset_n, running, lock_lost, retry_count);
        end

        for (int i = 0; i < 50 && sb.size() > 0; i++) tick(1);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            total++;
            bad++;
            $display("FAIL %s: never checked (due cycle %0d)", e.name, e.cyc);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
